// File: rtl/red_pitaya_dac_pkg.sv
// Shared definitions for the DAC output conditioning stage: FSM encoding,
// unity gain and the saturation bounds for the default sample/gain widths.
package red_pitaya_dac_pkg;

    localparam int DEF_DW = 14;
    localparam int DEF_GW = 14;

    // unity gain sits one bit below the top of the gain word
    localparam int GAIN_UNITY = 1 << (DEF_GW - 1);

    // output range of a DEF_DW-bit signed sample
    localparam int SAT_HI = (1 << (DEF_DW - 1)) - 1;
    localparam int SAT_LO = -(1 << (DEF_DW - 1));

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_FADE_IN  = 2'd1,
        ST_ON       = 2'd2,
        ST_FADE_OUT = 2'd3
    } fade_state_t;

endpackage

// File: rtl/red_pitaya_slew_lim.sv
// Input register plus per-cycle slew limiter (pipeline stages S1 and S2).
module red_pitaya_slew_lim #(
    parameter int DW = 14
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic signed [DW-1:0] din,
    input  logic        [DW-1:0] slew,
    output logic signed [DW-1:0] dout
);

    logic signed [DW-1:0] din_r;
    logic signed [DW+1:0] diff;
    logic signed [DW+1:0] lim;
    logic signed [DW+1:0] up;
    logic signed [DW+1:0] dn;

    // two extra bits keep the full -8192..+8191 swing and the limit itself from wrapping
    always_comb begin
        lim  = $signed({2'b00, slew});
        diff = (DW+2)'(din_r) - (DW+2)'(dout);
        up   = (DW+2)'(dout) + lim;
        dn   = (DW+2)'(dout) - lim;
    end

    // S1 captures the sample, S2 steps towards it by at most slew per cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            din_r <= '0;
            dout  <= '0;
        end else begin
            din_r <= din;
            if (slew == '0)
                dout <= din_r;
            else if (diff > lim)
                dout <= up[DW-1:0];   // stays below din_r, so fits in DW bits
            else if (diff < -lim)
                dout <= dn[DW-1:0];
            else
                dout <= din_r;
        end
    end

endmodule

// File: rtl/red_pitaya_dac_fade.sv
// Per-channel DAC output conditioning: slew limit, then a linear gain
// envelope that fades the channel in and out on enable changes.
module red_pitaya_dac_fade
    import red_pitaya_dac_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int GW = DEF_GW
) (
    input  logic                 dac_clk_i,
    input  logic                 dac_rst_i,
    input  logic signed [DW-1:0] dat_i,
    input  logic                 enable_i,
    input  logic                 kill_i,
    input  logic        [DW-1:0] set_slew_i,
    input  logic        [GW-1:0] set_fade_step_i,
    output logic signed [DW-1:0] dac_o,
    output logic        [1:0]    state_o,
    output logic                 busy_o
);

    localparam int                   PW    = 2*DW + 1;
    localparam logic        [GW:0]   UNITY = (GW+1)'(GAIN_UNITY);
    localparam logic signed [PW-1:0] HI_W  = PW'(SAT_HI);
    localparam logic signed [PW-1:0] LO_W  = PW'(SAT_LO);

    fade_state_t          st_q, st_d;
    logic        [GW-1:0] gain_q, gain_d;
    logic        [GW:0]   g_up, g_dn;
    logic signed [DW-1:0] slw;
    logic signed [PW-1:0] mult_r;
    logic signed [PW-1:0] shifted;
    logic signed [DW-1:0] sat_d;

    red_pitaya_slew_lim #(.DW(DW)) u_slew (
        .clk  (dac_clk_i),
        .rst  (dac_rst_i),
        .din  (dat_i),
        .slew (set_slew_i),
        .dout (slw)
    );

    // envelope state and gain register
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i) begin
            st_q   <= ST_OFF;
            gain_q <= '0;
        end else begin
            st_q   <= st_d;
            gain_q <= gain_d;
        end
    end

    // next state/gain; gain math one bit wider so ramps clamp instead of wrapping
    always_comb begin
        st_d   = st_q;
        gain_d = gain_q;
        g_up   = {1'b0, gain_q} + {1'b0, set_fade_step_i};
        g_dn   = {1'b0, gain_q} - {1'b0, set_fade_step_i};
        if (kill_i) begin
            st_d   = ST_OFF;
            gain_d = '0;
        end else begin
            case (st_q)
                ST_OFF: begin
                    gain_d = '0;
                    if (enable_i) begin
                        if (set_fade_step_i == '0) begin
                            st_d   = ST_ON;
                            gain_d = UNITY[GW-1:0];
                        end else begin
                            st_d = ST_FADE_IN;
                        end
                    end
                end
                ST_FADE_IN: begin
                    if (!enable_i) begin
                        st_d = ST_FADE_OUT;          // reverse from the current gain
                    end else if (g_up >= UNITY) begin
                        st_d   = ST_ON;
                        gain_d = UNITY[GW-1:0];
                    end else begin
                        gain_d = g_up[GW-1:0];
                    end
                end
                ST_ON: begin
                    gain_d = UNITY[GW-1:0];
                    if (!enable_i) begin
                        if (set_fade_step_i == '0) begin
                            st_d   = ST_OFF;
                            gain_d = '0;
                        end else begin
                            st_d = ST_FADE_OUT;
                        end
                    end
                end
                ST_FADE_OUT: begin
                    if (enable_i) begin
                        st_d = ST_FADE_IN;
                    end else if (g_dn[GW] || g_dn == '0) begin
                        st_d   = ST_OFF;
                        gain_d = '0;
                    end else begin
                        gain_d = g_dn[GW-1:0];
                    end
                end
                default: begin
                    st_d   = ST_OFF;
                    gain_d = '0;
                end
            endcase
        end
    end

    // S3: apply gain; operands widened so the product is exact
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i)
            mult_r <= '0;
        else
            mult_r <= PW'(slw) * PW'($signed({1'b0, gain_q}));
    end

    // rescale and clamp; unreachable for gain <= unity but kept as a guard
    always_comb begin
        shifted = mult_r >>> (GW-1);
        sat_d   = shifted[DW-1:0];
        if (shifted > HI_W)
            sat_d = HI_W[DW-1:0];
        else if (shifted < LO_W)
            sat_d = LO_W[DW-1:0];
    end

    // S4: output register
    always_ff @(posedge dac_clk_i) begin
        if (dac_rst_i)
            dac_o <= '0;
        else
            dac_o <= sat_d;
    end

    assign state_o = st_q;
    assign busy_o  = (st_q == ST_FADE_IN) || (st_q == ST_FADE_OUT);

endmodule

// File: tb/tb_red_pitaya_dac_fade.sv
// Bench for red_pitaya_dac_fade: slew vectors from a table through a
// scoreboard, then hand-written fade / abort / reset sequences.
module tb_red_pitaya_dac_fade;
    import red_pitaya_dac_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [13:0] din;
    logic               en, kill;
    logic        [13:0] slew, step;
    logic signed [13:0] dac_o;
    logic        [1:0]  state_o;
    logic               busy_o;

    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        [13:0] slew;
        logic signed [13:0] din;
        logic signed [13:0] exp;
    } vec_t;

    typedef struct {
        int                 cyc;
        logic signed [13:0] exp;
        string              tag;
    } sb_t;

    vec_t tbl[$];
    sb_t  sbq[$];

    red_pitaya_dac_fade dut (
        .dac_clk_i       (clk),
        .dac_rst_i       (rst),
        .dat_i           (din),
        .enable_i        (en),
        .kill_i          (kill),
        .set_slew_i      (slew),
        .set_fade_step_i (step),
        .dac_o           (dac_o),
        .state_o         (state_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard: compare every expectation due at this edge
    always @(negedge clk) begin : mon
        sb_t e;
        while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
            e = sbq.pop_front();
            total++;
            if (e.cyc != cyc || dac_o !== e.exp) begin
                bad++;
                $display("FAIL %s cyc=%0d due=%0d dac_o=%0d want=%0d", e.tag, cyc, e.cyc, dac_o, e.exp);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic add(input int s, input int d, input int e);
        vec_t v;
        v.slew = 14'(s);
        v.din  = 14'(d);
        v.exp  = 14'(e);
        tbl.push_back(v);
    endtask

    // one envelope update with din held at 4000; dac_o follows gain two edges later
    task automatic step_chk(input logic e, input logic k, input logic [1:0] st, input int g, input string nm);
        en   = e;
        kill = k;
        tick();
        kill = 1'b0;
        chk({nm, "_state"}, state_o, st);
        chk({nm, "_busy"}, busy_o, (st == ST_FADE_IN || st == ST_FADE_OUT) ? 1 : 0);
        sbq.push_back('{cyc + 2, 14'((4000 * g) / 8192), {nm, "_dac"}});
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && sbq.size() > 0; i++) tick();
        if (sbq.size() > 0) begin
            total++;
            bad++;
            $display("FAIL drain pending=%0d", sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        // slew segments; each ends on a repeated value so the next segment's limit starts clean
        add(100, 0, 0);
        add(100, 0, 0);
        for (int i = 1; i <= 10; i++) add(100, 1000, 100 * i);
        add(100, 1000, 1000);
        add(100, 1000, 1000);
        for (int i = 0; i < 4; i++) add(0, 4096, 4096);
        for (int i = 0; i < 2; i++) begin
            add(16383, 8191, 8191);
            add(16383, -8192, -8192);
        end
        add(16383, 8191, 8191);
        add(16383, 8191, 8191);
        add(5000, -8192, 3191);
        add(5000, -8192, -1809);
        add(5000, -8192, -6809);
        add(5000, -8192, -8192);
        add(5000, -8192, -8192);
        add(5000, 8191, -3192);
        add(5000, 8191, 1808);
        add(5000, 8191, 6808);
        add(5000, 8191, 8191);
        add(5000, 8191, 8191);

        rst = 1'b1; din = '0; en = 1'b0; kill = 1'b0; slew = '0; step = '0;
        tick();
        tick();
        chk("rst_dac", dac_o, 0);
        chk("rst_state", state_o, ST_OFF);
        chk("rst_busy", busy_o, 0);
        rst = 1'b0;

        // step 0 enable: straight to ON
        en = 1'b1;
        tick();
        chk("bypass_state", state_o, ST_ON);
        chk("bypass_busy", busy_o, 0);

        foreach (tbl[i]) begin
            slew = tbl[i].slew;
            din  = tbl[i].din;
            sbq.push_back('{cyc + 4, tbl[i].exp, $sformatf("vec%0d", i)});
            tick();
        end
        drain();

        // fade-in from OFF at step 1024
        din = 14'sd4000; slew = '0; step = '0;
        step_chk(0, 0, ST_OFF, 0, "off_step0");
        for (int i = 0; i < 3; i++) step_chk(0, 0, ST_OFF, 0, "off_idle");
        step = 14'd1024;
        step_chk(1, 0, ST_FADE_IN, 0, "fin0");
        for (int i = 1; i <= 7; i++) step_chk(1, 0, ST_FADE_IN, 1024 * i, $sformatf("fin%0d", i));
        step_chk(1, 0, ST_ON, 8192, "fin8");
        step_chk(1, 0, ST_ON, 8192, "on_hold");
        step_chk(1, 0, ST_ON, 8192, "on_hold");

        // kill from ON, ramp up to 3072, then reverse
        step_chk(1, 1, ST_OFF, 0, "kill_on");
        step_chk(1, 0, ST_FADE_IN, 0, "rev_in0");
        step_chk(1, 0, ST_FADE_IN, 1024, "rev_in1");
        step_chk(1, 0, ST_FADE_IN, 2048, "rev_in2");
        step_chk(1, 0, ST_FADE_IN, 3072, "rev_in3");
        step_chk(0, 0, ST_FADE_OUT, 3072, "rev_out0");
        step_chk(0, 0, ST_FADE_OUT, 2048, "rev_out1");
        step_chk(0, 0, ST_FADE_OUT, 1024, "rev_out2");
        step_chk(0, 0, ST_OFF, 0, "rev_off");
        step_chk(0, 0, ST_OFF, 0, "rev_settle");
        step_chk(0, 0, ST_OFF, 0, "rev_settle");

        // kill mid fade-in
        step_chk(1, 0, ST_FADE_IN, 0, "abort_in0");
        step_chk(1, 0, ST_FADE_IN, 1024, "abort_in1");
        step_chk(1, 1, ST_OFF, 0, "abort_kill");
        step_chk(0, 0, ST_OFF, 0, "abort_idle");
        step_chk(0, 0, ST_OFF, 0, "abort_idle");

        // step changed mid-fade, ramp clamps at unity
        step_chk(1, 0, ST_FADE_IN, 0, "chg_in0");
        step_chk(1, 0, ST_FADE_IN, 1024, "chg_in1");
        step = 14'd3000;
        step_chk(1, 0, ST_FADE_IN, 4024, "chg_in2");
        step_chk(1, 0, ST_FADE_IN, 7024, "chg_in3");
        step_chk(1, 0, ST_ON, 8192, "chg_clamp");
        step = '0;
        step_chk(0, 0, ST_OFF, 0, "on_off_instant");
        step_chk(1, 0, ST_ON, 8192, "off_on_instant");
        step_chk(1, 0, ST_ON, 8192, "on_hold2");
        step_chk(1, 0, ST_ON, 8192, "on_hold2");
        drain();
        chk("pre_rst_dac", dac_o, 4000);

        // synchronous reset while ON
        rst = 1'b1;
        tick();
        chk("midrst_dac", dac_o, 0);
        chk("midrst_state", state_o, ST_OFF);
        chk("midrst_busy", busy_o, 0);
        rst = 1'b0;
        en  = 1'b0;
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
